// File: rtl/sync_wait_merge_mmu.sv
// N-way wait-merge (join) with one FIFO per input channel and a per-token
// enable mask; emits one merged token when every enabled channel has data.
module sync_wait_merge_mmu #(
    parameter  int NUM_PORTS = 3,
    parameter  int DATA_W    = 8,
    parameter  int DEPTH     = 2,
    localparam int PW        = $clog2(DEPTH),
    localparam int LW        = PW + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          i_drive,
    input  logic [NUM_PORTS*DATA_W-1:0]   i_data,
    output logic [NUM_PORTS-1:0]          o_free,
    input  logic [NUM_PORTS-1:0]          i_portMask,
    output logic                          o_driveNext,
    output logic [NUM_PORTS*DATA_W-1:0]   o_data,
    output logic [NUM_PORTS-1:0]          o_fireMask,
    input  logic                          i_freeNext,
    output logic [NUM_PORTS*LW-1:0]       o_level,
    output logic [15:0]                   o_fireCount
);

    logic [DATA_W-1:0]           r_mem   [NUM_PORTS][DEPTH];
    logic [PW-1:0]               r_wptr  [NUM_PORTS];
    logic [PW-1:0]               r_rptr  [NUM_PORTS];
    logic [LW-1:0]               r_level [NUM_PORTS];

    logic                        r_drive_next;
    logic [NUM_PORTS*DATA_W-1:0] r_data;
    logic [NUM_PORTS-1:0]        r_fire_mask;
    logic [15:0]                 r_fire_count;

    logic [NUM_PORTS-1:0]        w_full;
    logic [NUM_PORTS-1:0]        w_nonempty;
    logic [NUM_PORTS-1:0]        w_push;
    logic [NUM_PORTS-1:0]        w_pop;
    logic [NUM_PORTS*DATA_W-1:0] w_heads;
    logic [NUM_PORTS*LW-1:0]     w_level_flat;
    logic                        w_slot_ok;
    logic                        w_fire;

    // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        w_full       = '0;
        w_nonempty   = '0;
        w_heads      = '0;
        w_level_flat = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_full[i]                   = (r_level[i] == LW'(DEPTH));
            w_nonempty[i]               = (r_level[i] != '0);
            w_level_flat[i*LW +: LW]    = r_level[i];
            if (i_portMask[i])
                w_heads[i*DATA_W +: DATA_W] = r_mem[i][r_rptr[i]];
        end
    end

    // Readiness comes from registered occupancy only: a full FIFO being popped stays not-ready.
    assign o_free    = ~w_full & {NUM_PORTS{~rst}};
    assign w_push    = i_drive & o_free;
    assign w_slot_ok = ~r_drive_next | i_freeNext;
    assign w_fire    = w_slot_ok & (|i_portMask) & (&(w_nonempty | ~i_portMask));
    assign w_pop     = i_portMask & {NUM_PORTS{w_fire}};

    // NOTE: payload storage has no reset; pointers and levels alone decide what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_push[i])
                r_mem[i][r_wptr[i]] <= i_data[i*DATA_W +: DATA_W];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every block sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_wptr[i]  <= '0;
                r_rptr[i]  <= '0;
                r_level[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_push[i])
                    r_wptr[i] <= r_wptr[i] + PW'(1);
                if (w_pop[i])
                    r_rptr[i] <= r_rptr[i] + PW'(1);
                case ({w_push[i], w_pop[i]})
                    2'b10:   r_level[i] <= r_level[i] + LW'(1);
                    2'b01:   r_level[i] <= r_level[i] - LW'(1);
                    default: r_level[i] <= r_level[i];
                endcase
            end
        end
    end

    // Output slot: loads on fire, otherwise drains when downstream accepts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drive_next <= 1'b0;
            r_data       <= '0;
            r_fire_mask  <= '0;
            r_fire_count <= '0;
        end else if (w_fire) begin
            r_drive_next <= 1'b1;
            r_data       <= w_heads;
            r_fire_mask  <= i_portMask;
            r_fire_count <= r_fire_count + 16'd1;
        end else if (i_freeNext) begin
            r_drive_next <= 1'b0;
        end
    end

    assign o_driveNext = r_drive_next;
    assign o_data      = r_data;
    assign o_fireMask  = r_fire_mask;
    assign o_fireCount = r_fire_count;
    assign o_level     = w_level_flat;

endmodule

// File: tb/tb_sync_wait_merge_mmu.sv
// Directed bench for sync_wait_merge_mmu with default parameters
// (3 ports, 8-bit lanes, depth 2); expected values are hand-computed.
module tb_sync_wait_merge_mmu;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  i_drive;
    logic [23:0] i_data;
    logic [2:0]  o_free;
    logic [2:0]  i_portMask;
    logic        o_driveNext;
    logic [23:0] o_data;
    logic [2:0]  o_fireMask;
    logic        i_freeNext;
    logic [5:0]  o_level;
    logic [15:0] o_fireCount;

    int n_tests = 0;
    int n_fail  = 0;

    sync_wait_merge_mmu #(.NUM_PORTS(3), .DATA_W(8), .DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_drive     (i_drive),
        .i_data      (i_data),
        .o_free      (o_free),
        .i_portMask  (i_portMask),
        .o_driveNext (o_driveNext),
        .o_data      (o_data),
        .o_fireMask  (o_fireMask),
        .i_freeNext  (i_freeNext),
        .o_level     (o_level),
        .o_fireCount (o_fireCount)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] tok(int k);
        logic [23:0] t;
        for (int i = 0; i < 3; i++) t[i*8 +: 8] = 8'(k * 3 + i);
        return t;
    endfunction

    task automatic test_reset();
        rst = 1'b1; i_drive = '0; i_data = '0; i_portMask = 3'b111; i_freeNext = 1'b1;
        #1;
        n_tests++;
        if ({o_free, o_level, o_driveNext, o_data, o_fireMask, o_fireCount} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: free=%b level=%b dn=%b data=%h fm=%b cnt=%h want all zero",
                     o_free, o_level, o_driveNext, o_data, o_fireMask, o_fireCount);
        end
        tick(); tick();
        rst = 1'b0;
        #1;
        n_tests++;
        if ({o_free, o_level, o_driveNext} !== {3'b111, 6'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_release: free=%b level=%b dn=%b want 111 000000 0", o_free, o_level, o_driveNext);
        end
    endtask

    task automatic test_sequencing();
        for (int e = 0; e < 5; e++) begin
            i_drive = (e == 0) ? 3'b001 : (e == 2) ? 3'b010 : (e == 4) ? 3'b100 : 3'b000;
            i_data  = 24'h332211;
            tick();
            n_tests++;
            if (o_driveNext !== 1'b0) begin
                n_fail++;
                $display("FAIL seq_early_fire edge %0d: dn=%b want 0", e, o_driveNext);
            end
        end
        i_drive = '0;
        tick();
        n_tests++;
        if ({o_driveNext, o_data, o_fireMask, o_fireCount, o_level} !== {1'b1, 24'h332211, 3'b111, 16'd1, 6'd0}) begin
            n_fail++;
            $display("FAIL seq_fire: dn=%b data=%h fm=%b cnt=%0d level=%b want 1 332211 111 1 000000",
                     o_driveNext, o_data, o_fireMask, o_fireCount, o_level);
        end
        tick();
        n_tests++;
        if ({o_driveNext, o_data} !== {1'b0, 24'h332211}) begin
            n_fail++;
            $display("FAIL seq_drain: dn=%b data=%h want 0 332211", o_driveNext, o_data);
        end
    endtask

    task automatic test_backpressure();
        i_portMask = 3'b111; i_freeNext = 1'b0; i_drive = 3'b001;
        i_data = 24'h000041; tick();
        n_tests++;
        if ({o_free[0], o_level[1:0]} !== {1'b1, 2'd1}) begin
            n_fail++;
            $display("FAIL bp_first: free0=%b lvl0=%0d want 1 1", o_free[0], o_level[1:0]);
        end
        i_data = 24'h000042; tick();
        n_tests++;
        if ({o_free[0], o_level[1:0]} !== {1'b0, 2'd2}) begin
            n_fail++;
            $display("FAIL bp_full: free0=%b lvl0=%0d want 0 2", o_free[0], o_level[1:0]);
        end
        i_data = 24'h000043; tick();
        n_tests++;
        if ({o_free[0], o_level[1:0], o_driveNext} !== {1'b0, 2'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_reject: free0=%b lvl0=%0d dn=%b want 0 2 0", o_free[0], o_level[1:0], o_driveNext);
        end
        i_drive = '0; i_portMask = 3'b001;
        tick();
        n_tests++;
        if ({o_driveNext, o_data, o_fireMask, o_fireCount, o_level[1:0]} !== {1'b1, 24'h000041, 3'b001, 16'd2, 2'd1}) begin
            n_fail++;
            $display("FAIL bp_out1: dn=%b data=%h fm=%b cnt=%0d lvl0=%0d want 1 000041 001 2 1",
                     o_driveNext, o_data, o_fireMask, o_fireCount, o_level[1:0]);
        end
        tick();
        n_tests++;
        if ({o_driveNext, o_data, o_fireCount, o_level[1:0]} !== {1'b1, 24'h000041, 16'd2, 2'd1}) begin
            n_fail++;
            $display("FAIL bp_stall_hold: dn=%b data=%h cnt=%0d lvl0=%0d want 1 000041 2 1",
                     o_driveNext, o_data, o_fireCount, o_level[1:0]);
        end
        i_freeNext = 1'b1;
        tick();
        n_tests++;
        if ({o_driveNext, o_data, o_fireCount, o_level, o_free} !== {1'b1, 24'h000042, 16'd3, 6'd0, 3'b111}) begin
            n_fail++;
            $display("FAIL bp_out2: dn=%b data=%h cnt=%0d level=%b free=%b want 1 000042 3 000000 111",
                     o_driveNext, o_data, o_fireCount, o_level, o_free);
        end
        tick();
        n_tests++;
        if ({o_driveNext, o_data} !== {1'b0, 24'h000042}) begin
            n_fail++;
            $display("FAIL bp_drain: dn=%b data=%h want 0 000042", o_driveNext, o_data);
        end
    endtask

    task automatic test_partial_mask();
        i_portMask = 3'b000; i_drive = 3'b111; i_data = 24'hC2B1A0;
        tick();
        i_drive = '0;
        n_tests++;
        if ({o_level, o_driveNext} !== {6'b01_01_01, 1'b0}) begin
            n_fail++;
            $display("FAIL mask_zero_nofire: level=%b dn=%b want 010101 0", o_level, o_driveNext);
        end
        i_portMask = 3'b101;
        tick();
        n_tests++;
        if ({o_driveNext, o_data, o_fireMask, o_fireCount, o_level} !== {1'b1, 24'hC200A0, 3'b101, 16'd4, 6'b00_01_00}) begin
            n_fail++;
            $display("FAIL mask_101: dn=%b data=%h fm=%b cnt=%0d level=%b want 1 c200a0 101 4 000100",
                     o_driveNext, o_data, o_fireMask, o_fireCount, o_level);
        end
        tick();
        n_tests++;
        if ({o_driveNext, o_level} !== {1'b0, 6'b00_01_00}) begin
            n_fail++;
            $display("FAIL mask_101_empty: dn=%b level=%b want 0 000100", o_driveNext, o_level);
        end
        i_portMask = 3'b010;
        tick();
        n_tests++;
        if ({o_driveNext, o_data, o_fireMask, o_fireCount, o_level} !== {1'b1, 24'h00B100, 3'b010, 16'd5, 6'd0}) begin
            n_fail++;
            $display("FAIL mask_010: dn=%b data=%h fm=%b cnt=%0d level=%b want 1 00b100 010 5 000000",
                     o_driveNext, o_data, o_fireMask, o_fireCount, o_level);
        end
        tick();
    endtask

    task automatic test_reset_in_flight();
        i_portMask = 3'b000; i_freeNext = 1'b0; i_drive = 3'b011; i_data = 24'h006151;
        tick();
        i_portMask = 3'b001; i_drive = 3'b001; i_data = 24'h000052;
        tick();
        i_data = 24'h000053;
        tick();
        i_drive = '0;
        n_tests++;
        if ({o_level, o_driveNext, o_data} !== {6'b00_01_10, 1'b1, 24'h000051}) begin
            n_fail++;
            $display("FAIL rif_setup: level=%b dn=%b data=%h want 000110 1 000051", o_level, o_driveNext, o_data);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if ({o_free, o_level, o_driveNext, o_data, o_fireMask, o_fireCount} !== '0) begin
            n_fail++;
            $display("FAIL rif_async_clear: free=%b level=%b dn=%b data=%h fm=%b cnt=%h want all zero",
                     o_free, o_level, o_driveNext, o_data, o_fireMask, o_fireCount);
        end
        tick();
        rst = 1'b0;
        #1;
        n_tests++;
        if ({o_free, o_level} !== {3'b111, 6'd0}) begin
            n_fail++;
            $display("FAIL rif_release: free=%b level=%b want 111 000000", o_free, o_level);
        end
        i_freeNext = 1'b1; i_portMask = 3'b111;
        tick();
        n_tests++;
        if (o_driveNext !== 1'b0) begin
            n_fail++;
            $display("FAIL rif_no_pulse: dn=%b want 0", o_driveNext);
        end
        i_drive = 3'b111; i_data = 24'h737271;
        tick();
        i_drive = '0;
        tick();
        n_tests++;
        if ({o_driveNext, o_data, o_fireMask, o_fireCount} !== {1'b1, 24'h737271, 3'b111, 16'd1}) begin
            n_fail++;
            $display("FAIL rif_new_data: dn=%b data=%h fm=%b cnt=%0d want 1 737271 111 1",
                     o_driveNext, o_data, o_fireMask, o_fireCount);
        end
        tick();
    endtask

    task automatic test_streaming();
        rst = 1'b1; #1; rst = 1'b0;
        i_portMask = 3'b111; i_freeNext = 1'b1;
        for (int k = 0; k < 100; k++) begin
            i_drive = 3'b111; i_data = tok(k);
            tick();
            n_tests++;
            if (k == 0) begin
                if ({o_driveNext, o_level} !== {1'b0, 6'b01_01_01}) begin
                    n_fail++;
                    $display("FAIL stream_first: dn=%b level=%b want 0 010101", o_driveNext, o_level);
                end
            end else if ({o_driveNext, o_data, o_level, o_free} !== {1'b1, tok(k - 1), 6'b01_01_01, 3'b111}) begin
                n_fail++;
                $display("FAIL stream_beat %0d: dn=%b data=%h level=%b free=%b want 1 %h 010101 111",
                         k, o_driveNext, o_data, o_level, o_free, tok(k - 1));
            end
        end
        i_drive = '0;
        tick();
        n_tests++;
        if ({o_driveNext, o_data, o_fireCount, o_level} !== {1'b1, tok(99), 16'd100, 6'd0}) begin
            n_fail++;
            $display("FAIL stream_end: dn=%b data=%h cnt=%0d level=%b want 1 %h 100 000000",
                     o_driveNext, o_data, o_fireCount, o_level, tok(99));
        end
        tick();
    endtask

    task automatic test_counter_wrap();
        rst = 1'b1; #1; rst = 1'b0;
        i_portMask = 3'b001; i_freeNext = 1'b1; i_drive = 3'b001; i_data = 24'h0000AA;
        repeat (65536) tick();
        n_tests++;
        if (o_fireCount !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL wrap_max: cnt=%h want ffff", o_fireCount);
        end
        tick();
        n_tests++;
        if ({o_fireCount, o_driveNext} !== {16'h0000, 1'b1}) begin
            n_fail++;
            $display("FAIL wrap_zero: cnt=%h dn=%b want 0000 1", o_fireCount, o_driveNext);
        end
        i_drive = '0;
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_sequencing();
        test_backpressure();
        test_partial_mask();
        test_reset_in_flight();
        test_streaming();
        test_counter_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_wait_merge_mmu.md
# sync_wait_merge_mmu

Clocked, parametrised N-way wait-merge (join) for the MMU datapath. It collects one token from every enabled input channel and emits a single merged token downstream. Each input channel has a small FIFO, so producers can run ahead of one another by up to DEPTH tokens. Unlike the fixed 3-port click-based merge, it takes a configurable channel count and data width, and a per-token port-enable mask (partial join). It also exposes fill levels and a fire counter, and it sits between the page-walk sub-requests and the TLB refill stage.

## Interface
Parameters:
- NUM_PORTS, 3: number of input channels, minimum 2.
- DATA_W, 8: payload width per channel, minimum 1.
- DEPTH, 2: per-channel FIFO depth; a power of 2, minimum 2. LW = log2(DEPTH)+1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_drive  in  NUM_PORTS  per-channel valid.
- i_data  in  NUM_PORTS*DATA_W  per-channel payload; channel i occupies bits [i*DATA_W +: DATA_W].
- o_free  out  NUM_PORTS  per-channel ready.
- i_portMask  in  NUM_PORTS  enabled channels for the next merge.
- o_driveNext  out  1  merged output valid.
- o_data  out  NUM_PORTS*DATA_W  merged payload; lanes of disabled channels are zero.
- o_fireMask  out  NUM_PORTS  copy of the mask used for the token currently on o_data.
- i_freeNext  in  1  downstream ready.
- o_level  out  NUM_PORTS*LW  per-channel FIFO occupancy.
- o_fireCount  out  16  count of merges.

## Operation
- Push on channel i: i_drive[i] & o_free[i] at a rising edge writes i_data lane i into FIFO i.
- o_free[i] = (level[i] != DEPTH) & ~rst. It is derived from registered occupancy; there is no same-cycle bypass, so a full FIFO stays not-ready for the whole cycle even if it is being popped.
- Output slot available: slot_ok = ~o_driveNext | i_freeNext.
- Merge condition: fire = slot_ok & (i_portMask != 0) & (level[i] != 0 for every i with i_portMask[i] = 1).
- On fire:
  - Pop the head of every enabled FIFO only.
  - Load o_data: head entries in enabled lanes, zero in disabled lanes.
  - Load o_fireMask <= i_portMask and set o_driveNext <= 1.
  - Increment o_fireCount, wrapping 0xFFFF -> 0x0000.
- Disabled channels keep their contents and continue to accept pushes until full.
- If no fire occurs and i_freeNext & o_driveNext, clear o_driveNext <= 0. o_data and o_fireMask hold their values.
- While o_driveNext & ~i_freeNext, o_data, o_fireMask and o_driveNext are stable.
- Push and pop on the same FIFO in the same cycle: the level is unchanged and ordering is FIFO, with the old head leaving.
- Pointers are log2(DEPTH) bits and wrap naturally. Level is LW bits in the range 0..DEPTH.
- i_portMask = 0: no fire, FIFOs untouched.

## Timing
- Reset values (asynchronous, take effect immediately):
  - FIFOs empty, o_level = 0.
  - o_driveNext = 0, o_data = 0, o_fireMask = 0, o_fireCount = 0.
  - o_free = 0 while rst = 1, and all 1 in the first cycle after release.
- Reset mid-operation discards all buffered and in-flight tokens. No output pulse is produced on release.
- Latency: the last required push accepted at edge k gives fire at edge k+1, so o_driveNext is high after edge k+1.
- Throughput: one merge per cycle when i_freeNext is held at 1 and all enabled FIFOs stay non-empty.
- Backpressure: downstream stall fills the FIFOs to DEPTH, then o_free drops. There is no loss and no duplication.

## Test plan
- Sequencing: NUM_PORTS=3, DATA_W=8, mask=3'b111; push 0x11 (port 0, cycle 0), 0x22 (port 1, cycle 2), 0x33 (port 2, cycle 4) -> o_driveNext rises after edge 5 with o_data=0x332211, o_fireCount=1; nothing fires earlier.
- Backpressure: i_freeNext=0, DEPTH=2, port 0 pushes 3 tokens -> o_free[0]=0 after 2 accepted and o_level[0]=2. Release i_freeNext -> tokens emerge in order.
- Partial mask: mask=3'b101 with ports 0 and 2 holding 0xA0 and 0xC2, port 1 holding 0xB1 -> o_data=0xC200A0, o_fireMask=3'b101; port 1 level stays 1.
- Streaming: continuous pushes on all ports and i_freeNext=1 -> one merge per cycle over 100 cycles, o_fireCount=100; all pointers wrap cleanly.
- Reset in flight: rst pulsed with levels (2,1,0) and o_driveNext=1 -> all outputs return to reset values within the pulse. After release, o_free=3'b111 and the first merge uses only new data.
- Counter wrap: force 65536 merges -> o_fireCount wraps from 0xFFFF to 0x0000.
